// File: rtl/aurora_bus_engine.sv
// aurora_bus_engine: round-robin burst engine for the parallel cPCI/DSP bus.
// Arbitrates W1/W2/R1/R2 requests and moves fixed-length bursts between local TX/RX streams and the bus.
module aurora_bus_engine #(
   parameter int BURST_LEN   = 256,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic        clk_in,
   input  logic        rst,
   input  logic        req_w_in_1,
   input  logic        req_w_in_2,
   input  logic        req_r_in_1,
   input  logic        req_r_in_2,
   input  logic        ack_in,
   input  logic        s_rdy_in,
   input  logic        abort_in,
   input  logic [31:0] adi_in,
   output logic [31:0] ado_in,
   output logic        ad_enable_in,
   output logic        we_in,
   output logic        stb_in,
   output logic        m_rdy_in,
   input  logic [31:0] tx_data_1,
   input  logic [31:0] tx_data_2,
   input  logic        tx_valid_1,
   input  logic        tx_valid_2,
   output logic        tx_ready_1,
   output logic        tx_ready_2,
   output logic [31:0] rx_data,
   output logic        rx_chan,
   output logic        rx_valid,
   input  logic        rx_ready,
   output logic        busy,
   output logic        burst_done,
   output logic        err_abort,
   output logic        err_timeout
);
   localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
   typedef enum logic [2:0] {IDLE, ADDR, WAIT_ACK, TURN, WDATA, RDATA, DONE, ERR} state_t;
   state_t state;
   logic [3:0] req;
   logic [1:0] code, ptr, gnt;
   logic gnt_ok, wdata, rdata, xfer, last;
   logic ad_en, stb, we, bsy, done, e_ab, e_to;
   logic [15:0] cnt;
   logic [TW-1:0] to_cnt;
   logic [31:0] addr_word;
   assign req = {req_r_in_2, req_r_in_1, req_w_in_2, req_w_in_1};
   assign wdata = state == WDATA;
   assign rdata = state == RDATA;
   assign m_rdy_in = wdata ? (code[0] ? tx_valid_2 : tx_valid_1) : rdata & rx_ready;
   assign xfer = m_rdy_in & s_rdy_in & ~abort_in;
   assign last = cnt == 16'(BURST_LEN - 1);
   assign ado_in = wdata ? (code[0] ? tx_data_2 : tx_data_1) : ad_en ? addr_word : '0;
   assign ad_enable_in = ad_en;
   assign we_in = we;
   assign stb_in = stb;
   assign busy = bsy;
   assign burst_done = done;
   assign err_abort = e_ab;
   assign err_timeout = e_to;
   assign tx_ready_1 = wdata & xfer & ~code[0];
   assign tx_ready_2 = wdata & xfer & code[0];
   assign rx_valid = rdata & xfer;
   assign rx_data = rx_valid ? adi_in : '0;
   assign rx_chan = rdata & code[0];
   // lowest offset from the round-robin pointer wins
   always_comb begin
      gnt_ok = 1'b0;
      gnt = ptr;
      for (int k = 3; k >= 0; k--)
         if (req[ptr + 2'(k)]) begin
            gnt_ok = 1'b1;
            gnt = ptr + 2'(k);
         end
   end
   always_ff @(posedge clk_in or posedge rst)
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         code <= '0;
         cnt <= '0;
         to_cnt <= '0;
         addr_word <= '0;
         ad_en <= 1'b0;
         stb <= 1'b0;
         we <= 1'b0;
         bsy <= 1'b0;
         done <= 1'b0;
         e_ab <= 1'b0;
         e_to <= 1'b0;
      end else begin
         stb <= 1'b0;
         done <= 1'b0;
         e_ab <= 1'b0;
         e_to <= 1'b0;
         // abort outranks ACK and completion in every post-address state
         if (abort_in && (state inside {WAIT_ACK, TURN, WDATA, RDATA})) begin
            state <= ERR;
            e_ab <= 1'b1;
            ad_en <= 1'b0;
            we <= 1'b0;
         end else
            case (state)
               IDLE:
                  if (gnt_ok) begin
                     state <= ADDR;
                     code <= gnt;
                     ptr <= gnt + 2'd1;
                     addr_word <= {gnt, 14'b0, 16'(BURST_LEN)};
                     stb <= 1'b1;
                     ad_en <= 1'b1;
                     we <= ~gnt[1];
                     bsy <= 1'b1;
                  end
               ADDR: begin
                  state <= WAIT_ACK;
                  ad_en <= we;
                  cnt <= '0;
                  to_cnt <= '0;
               end
               WAIT_ACK:
                  if (ack_in)
                     state <= we ? WDATA : TURN;
                  else if (to_cnt == TW'(ACK_TIMEOUT - 1)) begin
                     state <= ERR;
                     e_to <= 1'b1;
                     ad_en <= 1'b0;
                     we <= 1'b0;
                  end else
                     to_cnt <= to_cnt + 1'b1;
               TURN: state <= RDATA;
               WDATA, RDATA:
                  if (xfer) begin
                     cnt <= cnt + 16'd1;
                     if (last) begin
                        state <= DONE;
                        done <= 1'b1;
                        ad_en <= 1'b0;
                        we <= 1'b0;
                     end
                  end
               DONE, ERR: begin
                  state <= IDLE;
                  bsy <= 1'b0;
               end
               default: state <= IDLE;
            endcase
      end
endmodule

// File: tb/tb_aurora_bus_engine.sv
// tb_aurora_bus_engine: randomized scoreboard bench; stimulus queues expected bus/stream events,
// a negedge monitor pops and compares them as the engine presents them.
module tb_aurora_bus_engine;
   localparam int BL = 4;
   localparam int AT = 16;
   logic clk = 1'b0, rst = 1'b1;
   logic req_w_in_1 = 0, req_w_in_2 = 0, req_r_in_1 = 0, req_r_in_2 = 0;
   logic ack_in = 0, s_rdy_in = 0, abort_in = 0, rx_ready = 0;
   logic [31:0] adi_in = '0, tx_data_1 = '0, tx_data_2 = '0;
   logic tx_valid_1 = 0, tx_valid_2 = 0;
   logic [31:0] ado_in, rx_data;
   logic ad_enable_in, we_in, stb_in, m_rdy_in, tx_ready_1, tx_ready_2;
   logic rx_chan, rx_valid, busy, burst_done, err_abort, err_timeout;
   int vectors = 0, miscompares = 0, cycle = 0, stb_cyc = 0, ptr_m = 0;
   logic [32:0] exp_addr[$];
   logic [33:0] exp_word[$];
   logic [2:0] exp_end[$];

   aurora_bus_engine #(.BURST_LEN(BL), .ACK_TIMEOUT(AT)) dut (
      .clk_in(clk), .rst(rst),
      .req_w_in_1(req_w_in_1), .req_w_in_2(req_w_in_2), .req_r_in_1(req_r_in_1), .req_r_in_2(req_r_in_2),
      .ack_in(ack_in), .s_rdy_in(s_rdy_in), .abort_in(abort_in), .adi_in(adi_in),
      .ado_in(ado_in), .ad_enable_in(ad_enable_in), .we_in(we_in), .stb_in(stb_in), .m_rdy_in(m_rdy_in),
      .tx_data_1(tx_data_1), .tx_data_2(tx_data_2), .tx_valid_1(tx_valid_1), .tx_valid_2(tx_valid_2),
      .tx_ready_1(tx_ready_1), .tx_ready_2(tx_ready_2),
      .rx_data(rx_data), .rx_chan(rx_chan), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .busy(busy), .burst_done(burst_done), .err_abort(err_abort), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [79:0] a, input logic [79:0] e);
      vectors++;
      if (a !== e) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", nm, a, e);
      end
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      for (int k = 0; k < 4; k++)
         if (r[(p + k) % 4]) return (p + k) % 4;
      return 0;
   endfunction

   function automatic logic [79:0] all_out();
      return 80'({ado_in, rx_data, ad_enable_in, we_in, stb_in, m_rdy_in, tx_ready_1, tx_ready_2,
                  rx_chan, rx_valid, busy, burst_done, err_abort, err_timeout});
   endfunction

   // monitor: samples mid-cycle, after stimulus has settled
   always @(negedge clk) begin
      #2;
      cycle++;
      if (!rst) begin
         if (stb_in) begin
            stb_cyc = cycle;
            if (exp_addr.size() == 0) chk("extra_addr", 80'(ado_in), 80'(0));
            else chk("addr", 80'({ad_enable_in, we_in, ado_in}), 80'({1'b1, exp_addr.pop_front()}));
         end
         if (tx_ready_1 | tx_ready_2) begin
            if (exp_word.size() == 0) chk("extra_tx", 80'({tx_ready_2, tx_ready_1}), 80'(0));
            else begin
               logic [33:0] e;
               e = exp_word.pop_front();
               chk("tx_word", 80'({1'b1, tx_ready_2, ad_enable_in, m_rdy_in, ado_in}),
                   80'({e[33], e[32], 1'b1, 1'b1, e[31:0]}));
            end
         end
         if (rx_valid) begin
            if (exp_word.size() == 0) chk("extra_rx", 80'(rx_data), 80'(0));
            else begin
               logic [33:0] e;
               e = exp_word.pop_front();
               chk("rx_word", 80'({1'b0, rx_chan, ad_enable_in, rx_ready, rx_data}),
                   80'({e[33], e[32], 1'b0, 1'b1, e[31:0]}));
            end
         end
         if (burst_done | err_abort | err_timeout) begin
            if (exp_end.size() == 0) chk("extra_end", 80'({burst_done, err_abort, err_timeout}), 80'(0));
            else chk("end", 80'({burst_done, err_abort, err_timeout, ad_enable_in, stb_in}),
                     80'({exp_end.pop_front(), 2'b00}));
            if (err_timeout) chk("timeout_latency", 80'(cycle - stb_cyc), 80'(AT + 1));
         end
      end
   end

   // one burst: reference model queues the expectations, then plays the remote and the local streams
   task automatic do_burst(input logic [3:0] reqs, input int ack_dly, input int abort_at,
                           input bit rnd, input int rst_at);
      logic [1:0] g;
      bit wr, dp, aborted;
      int n, xf, cyc;
      logic [31:0] w[BL];
      g = 2'(rr_pick(reqs, ptr_m));
      ptr_m = (int'(g) + 1) % 4;
      wr = !g[1];
      for (int i = 0; i < BL; i++) w[i] = $urandom;
      n = ack_dly < 0 ? 0 : abort_at >= 0 ? abort_at : BL;
      exp_addr.push_back({wr, g, 14'b0, 16'(BL)});
      for (int i = 0; i < n; i++) exp_word.push_back({wr, g[0], w[i]});
      exp_end.push_back(ack_dly < 0 ? 3'b001 : abort_at >= 0 ? 3'b010 : 3'b100);
      {req_r_in_2, req_r_in_1, req_w_in_2, req_w_in_1} = reqs;
      cyc = 0;
      while (!stb_in && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      chk("grant_seen", 80'(stb_in), 80'(1));
      {req_r_in_2, req_r_in_1, req_w_in_2, req_w_in_1} = 4'b0;
      dp = 0;
      aborted = 0;
      xf = 0;
      for (cyc = 1; cyc <= 200; cyc++) begin
         @(negedge clk);
         if (!busy) break;
         if (ack_in) dp = 1;
         ack_in = cyc == ack_dly;
         s_rdy_in = rnd ? 1'($urandom) : 1'b1;
         rx_ready = rnd ? 1'($urandom) : cyc[0];
         tx_valid_1 = rnd ? 1'($urandom) : 1'b1;
         tx_valid_2 = rnd ? 1'($urandom) : 1'b1;
         abort_in = dp && !aborted && abort_at >= 0 && xf == abort_at;
         aborted |= abort_in;
         tx_data_1 = (wr && !g[0] && xf < BL) ? w[xf] : $urandom;
         tx_data_2 = (wr && g[0] && xf < BL) ? w[xf] : $urandom;
         adi_in = (!wr && xf < BL) ? w[xf] : $urandom;
         #1;
         if (dp && !abort_in && m_rdy_in && s_rdy_in) xf++;
         if (rst_at >= 0 && xf == rst_at) begin
            #2;
            rst = 1'b1;
            #1;
            chk("async_reset_outputs", all_out(), 80'(0));
            exp_addr.delete();
            exp_word.delete();
            exp_end.delete();
            ptr_m = 0;
            @(negedge clk);
            rst = 1'b0;
            break;
         end
      end
      chk("idle_after_burst", 80'(busy), 80'(0));
      {ack_in, abort_in, s_rdy_in, rx_ready, tx_valid_1, tx_valid_2} = '0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_outputs", all_out(), 80'(0));
      rst = 1'b0;
      @(negedge clk);
      do_burst(4'b0001, 3, -1, 0, -1);
      do_burst(4'b1000, 1, -1, 0, -1);
      for (int i = 0; i < 5; i++) do_burst(4'b1111, $urandom_range(1, 5), -1, 1, -1);
      do_burst(4'b0010, 2, 2, 0, -1);
      do_burst(4'b0100, -1, -1, 0, -1);
      for (int i = 0; i < 8; i++)
         do_burst(4'($urandom_range(1, 15)), $urandom_range(1, 6),
                  ($urandom_range(0, 3) == 0) ? $urandom_range(1, BL - 1) : -1, 1, -1);
      do_burst(4'b0001, 2, -1, 0, -1);
      do_burst(4'b0001, 1, -1, 0, 2);
      do_burst(4'b1111, 2, -1, 0, -1);
      repeat (3) @(negedge clk);
      chk("queues_drained", 80'(exp_addr.size() + exp_word.size() + exp_end.size()), 80'(0));
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/aurora_bus_engine.md
Name: aurora_bus_engine

Overview:
- Core-side protocol engine for the parallel cPCI/DSP bus. Sits directly behind the bus I/O buffer stage.
- Consumes the registered request, ACK, S_RDY and ABORT inputs.
- Drives the AD output word, AD enable, WE, STB and M_RDY, which the I/O stage registers into IOBs.
- Arbitrates four remote requests (write ch1/ch2, read ch1/ch2) and moves fixed-length bursts between two local TX streams and one RX stream.

Parameters:
- BURST_LEN, 256, words per burst; 1..65535.
- ACK_TIMEOUT, 1024, cycles to wait for ACK after the address phase before erroring.

Ports:
- clk_in  in  1  bus clock; same clock as the I/O stage
- rst  in  1  asynchronous, active-high reset
- req_w_in_1 / req_w_in_2  in  1  remote requests a write burst of channel 1 / 2 TX data
- req_r_in_1 / req_r_in_2  in  1  remote offers a read burst for channel 1 / 2
- ack_in  in  1  remote acknowledges the address phase
- s_rdy_in  in  1  slave ready for the current data word
- abort_in  in  1  remote aborts the current burst
- adi_in  in  32  read data from the bus
- ado_in  out  32  address/data word to the bus
- ad_enable_in  out  1  1 = engine drives AD
- we_in  out  1  1 = write burst
- stb_in  out  1  address strobe
- m_rdy_in  out  1  master ready for the current data word
- tx_data_1 / tx_data_2  in  32  local TX word, channel 1 / 2
- tx_valid_1 / tx_valid_2  in  1  local TX word valid
- tx_ready_1 / tx_ready_2  out  1  TX word consumed this cycle
- rx_data  out  32  received word
- rx_chan  out  1  0 = ch1, 1 = ch2
- rx_valid  out  1  rx_data valid, one-cycle pulse per word
- rx_ready  in  1  local RX sink has space
- busy  out  1  burst in progress
- burst_done  out  1  one-cycle pulse on normal completion
- err_abort  out  1  one-cycle pulse when a burst is aborted
- err_timeout  out  1  one-cycle pulse on ACK timeout

Behaviour:
- Reset: all outputs 0, state IDLE, round-robin pointer at W1. Reset mid-burst releases AD (ad_enable_in=0) immediately.
- States: IDLE, ADDR, WAIT_ACK, TURN, WDATA, RDATA, DONE, ERR.
- IDLE:
  - Sample the four requests and grant round-robin in the order W1, W2, R1, R2, starting after the last granted request.
  - No request: stay in IDLE.
  - Grant -> ADDR next cycle.
- ADDR, exactly 1 cycle:
  - stb_in=1, ad_enable_in=1, we_in=1 for write grants and 0 for read grants.
  - ado_in = {code[1:0], 14'b0, BURST_LEN[15:0]}, with code 00=W1, 01=W2, 10=R1, 11=R2.
  - Then -> WAIT_ACK with stb_in=0. AD stays driven for writes and is released for reads.
- WAIT_ACK:
  - Counter increments each cycle.
  - ack_in=1 -> WDATA for writes, TURN for reads.
  - Counter reaching ACK_TIMEOUT-1 without ACK -> ERR, with err_timeout.
- TURN: 1 cycle, ad_enable_in=0, then -> RDATA.
- WDATA:
  - ad_enable_in=1; ado_in = tx_data of the granted channel; m_rdy_in = tx_valid of that channel.
  - A word transfers in any cycle where m_rdy_in=1 and s_rdy_in=1. That cycle tx_ready of the granted channel = 1 and the word counter increments.
  - The other channel's tx_ready stays 0.
- RDATA:
  - ad_enable_in=0; m_rdy_in = rx_ready.
  - A word transfers when m_rdy_in=1 and s_rdy_in=1. Then rx_valid=1 and rx_data=adi_in of the same cycle; rx_chan = the granted channel.
- Completion: when the word counter reaches BURST_LEN, go to DONE. DONE lasts 1 cycle with all bus outputs 0, pulses burst_done, then -> IDLE.
- abort_in=1 in WAIT_ACK, TURN, WDATA or RDATA:
  - Go to ERR in the same cycle; no transfer is counted in that cycle even if s_rdy_in=1.
  - ERR lasts 1 cycle with all bus outputs 0, pulses err_abort, then -> IDLE.
  - Abort has priority over ACK and over completion.
- busy=1 in every state except IDLE.
- Word counter is 16 bits, cleared in ADDR, and never wraps: completion is checked before increment overflow.
- Requests arriving during a burst are ignored until the engine returns to IDLE. A request that is still high is re-arbitrated then.

Test Plan:
- Single W1 request, ACK after 3 cycles, tx_valid_1 and s_rdy_in held high, BURST_LEN=4 -> ADDR word 0x00000004 with stb_in=1 and we_in=1; 4 words driven in 4 consecutive cycles; tx_ready_1 pulses 4 times; burst_done pulses once; busy returns to 0.
- R2 request, ACK, s_rdy_in high, rx_ready toggling 1/0 -> ADDR word 0xC0000004 with we_in=0; one TURN cycle with ad_enable_in=0; exactly 4 rx_valid pulses, only in rx_ready=1 cycles; rx_chan=1; rx_data matches adi_in.
- All four requests held high -> grant order W1, W2, R1, R2, W1 across five bursts.
- W2 burst with abort_in asserted after the 2nd word -> ERR; err_abort pulses; ad_enable_in=0 next cycle; only 2 tx_ready_2 pulses; no burst_done.
- R1 request, ack_in never asserted, ACK_TIMEOUT=16 -> err_timeout pulses 16 cycles after entering WAIT_ACK; engine returns to IDLE.
- rst asserted in the middle of a WDATA burst -> all outputs 0 asynchronously; next grant restarts from W1 priority.
